// File: rtl/l1d_tag_update_sequencer_pkg.sv
// Shared L1D tag-pipeline definitions: geometry, index/tag types and the tag op encoding.
package l1d_tag_update_sequencer_pkg;

    localparam int unsigned L1D_NUM_WAYS    = 4;
    localparam int unsigned L1D_NUM_SETS    = 64;
    localparam int unsigned L1D_OFFSET_BITS = 6;
    localparam int unsigned L1D_SET_BITS    = $clog2(L1D_NUM_SETS);
    localparam int unsigned L1D_WAY_BITS    = $clog2(L1D_NUM_WAYS);
    localparam int unsigned L1D_TAG_BITS    = 32 - L1D_SET_BITS - L1D_OFFSET_BITS;

    typedef logic [L1D_TAG_BITS-1:0] l1d_tag_t;
    typedef logic [L1D_SET_BITS-1:0] l1d_set_idx_t;
    typedef logic [L1D_WAY_BITS-1:0] l1d_way_idx_t;

    typedef enum logic {
        TagOpFill  = 1'b0,
        TagOpInval = 1'b1
    } l1d_tag_op_e;

endpackage

// File: rtl/l1d_tag_update_sequencer_if.sv
// Request/completion bus between a tag-op requester (master) and the sequencer (slave).
interface l1d_tag_update_sequencer_if #(
    parameter int unsigned NUM_WAYS = l1d_tag_update_sequencer_pkg::L1D_NUM_WAYS
);
    import l1d_tag_update_sequencer_pkg::*;

    localparam int unsigned WAY_BITS = $clog2(NUM_WAYS);

    logic                req_valid;
    logic                req_ready;
    l1d_tag_op_e         req_op;
    logic [31:0]         req_paddr;
    logic                done_valid;
    logic                done_hit;
    logic [WAY_BITS-1:0] done_way;

    modport master (
        output req_valid, req_op, req_paddr,
        input  req_ready, done_valid, done_hit, done_way
    );

    modport slave (
        input  req_valid, req_op, req_paddr,
        output req_ready, done_valid, done_hit, done_way
    );

endinterface

// File: rtl/l1d_tag_update_sequencer_oh_to_idx.sv
// One-hot to binary index; with several bits set the lowest set index wins.
module l1d_tag_update_sequencer_oh_to_idx #(
    parameter  int unsigned WIDTH    = 4,
    localparam int unsigned IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]    oh_i,
    output logic [IDX_BITS-1:0] idx_o,
    output logic                any_o
);

    always_comb begin
        idx_o = '0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (oh_i[i]) begin
                idx_o = IDX_BITS'(i);
            end
        end
    end

    assign any_o = |oh_i;

endmodule

// File: rtl/l1d_tag_update_sequencer.sv
// Four-state sequencer: snoop tags, resolve hit/victim, write one tag way, pulse done.
module l1d_tag_update_sequencer
    import l1d_tag_update_sequencer_pkg::*;
#(
    parameter  int unsigned NUM_WAYS = L1D_NUM_WAYS,
    parameter  int unsigned NUM_SETS = L1D_NUM_SETS,
    localparam int unsigned SET_BITS = $clog2(NUM_SETS),
    localparam int unsigned WAY_BITS = $clog2(NUM_WAYS),
    localparam int unsigned TAG_BITS = 32 - SET_BITS - L1D_OFFSET_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    l1d_tag_update_sequencer_if.slave    req_if,
    output logic                         snoop_en,
    output logic [SET_BITS-1:0]          snoop_set,
    output logic                         lru_fill_en,
    output logic [SET_BITS-1:0]          lru_fill_set,
    input  logic [NUM_WAYS-1:0]          snoop_valid,
    input  logic [NUM_WAYS*TAG_BITS-1:0] snoop_tag,
    input  logic [WAY_BITS-1:0]          fill_lru,
    output logic [NUM_WAYS-1:0]          dtag_update_en_oh,
    output logic [SET_BITS-1:0]          dtag_update_set,
    output logic [TAG_BITS-1:0]          dtag_update_tag,
    output logic                         dtag_update_valid
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSnoop  = 2'd1;
    localparam logic [1:0] StCheck  = 2'd2;
    localparam logic [1:0] StUpdate = 2'd3;

    logic [1:0]          state_q, state_d;
    l1d_tag_op_e         op_q, op_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic                hit_any_q, hit_any_d;
    logic [WAY_BITS-1:0] hit_way_q, hit_way_d;
    logic [WAY_BITS-1:0] lru_q, lru_d;

    logic [NUM_WAYS-1:0] hit;
    logic [WAY_BITS-1:0] hit_idx;
    logic                hit_any;
    logic                accept;
    logic                is_fill;
    logic                do_write;
    logic [WAY_BITS-1:0] upd_way;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit[w] = snoop_valid[w] && (snoop_tag[w*TAG_BITS +: TAG_BITS] == tag_q);
        end
    end

    l1d_tag_update_sequencer_oh_to_idx #(
        .WIDTH (NUM_WAYS)
    ) u_oh_to_idx (
        .oh_i  (hit),
        .idx_o (hit_idx),
        .any_o (hit_any)
    );

    assign accept = req_if.req_valid && (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        set_d     = set_q;
        tag_d     = tag_q;
        hit_any_d = hit_any_q;
        hit_way_d = hit_way_q;
        lru_d     = lru_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSnoop;
                    op_d    = req_if.req_op;
                    set_d   = req_if.req_paddr[L1D_OFFSET_BITS +: SET_BITS];
                    tag_d   = req_if.req_paddr[31 -: TAG_BITS];
                end
            end
            StSnoop: state_d = StCheck;
            StCheck: begin
                // Tag stage answers one cycle after the snoop, so capture here.
                state_d   = StUpdate;
                hit_any_d = hit_any;
                hit_way_d = hit_idx;
                lru_d     = fill_lru;
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= TagOpFill;
            set_q     <= '0;
            tag_q     <= '0;
            hit_any_q <= 1'b0;
            hit_way_q <= '0;
            lru_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            set_q     <= set_d;
            tag_q     <= tag_d;
            hit_any_q <= hit_any_d;
            hit_way_q <= hit_way_d;
            lru_q     <= lru_d;
        end
    end

    assign is_fill  = (op_q == TagOpFill);
    // A fill that already hits refreshes the hit way rather than evicting the victim.
    assign upd_way  = (is_fill && !hit_any_q) ? lru_q : hit_way_q;
    assign do_write = is_fill || hit_any_q;

    always_comb begin
        req_if.req_ready   = (state_q == StIdle);
        req_if.done_valid  = 1'b0;
        req_if.done_hit    = 1'b0;
        req_if.done_way    = '0;
        snoop_en           = 1'b0;
        snoop_set          = '0;
        lru_fill_en        = 1'b0;
        lru_fill_set       = '0;
        dtag_update_en_oh  = '0;
        dtag_update_set    = '0;
        dtag_update_tag    = '0;
        dtag_update_valid  = 1'b0;
        if (state_q == StSnoop) begin
            snoop_en     = 1'b1;
            snoop_set    = set_q;
            lru_fill_en  = is_fill;
            lru_fill_set = is_fill ? set_q : '0;
        end
        if (state_q == StUpdate) begin
            req_if.done_valid = 1'b1;
            req_if.done_hit   = hit_any_q;
            req_if.done_way   = do_write ? upd_way : '0;
            dtag_update_set   = set_q;
            dtag_update_tag   = tag_q;
            dtag_update_valid = is_fill;
            if (do_write) begin
                dtag_update_en_oh = NUM_WAYS'(1) << upd_way;
            end
        end
    end

    a_single_hit : assert property (@(posedge clk) disable iff (reset)
        (state_q == StCheck) |-> $onehot0(hit));

    a_en_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(dtag_update_en_oh));

endmodule

// File: tb/tb_l1d_tag_update_sequencer.sv
// Scoreboarded bench for the L1D tag update sequencer.
module tb_l1d_tag_update_sequencer;
    import l1d_tag_update_sequencer_pkg::*;

    typedef struct {
        logic [3:0]  en;
        logic [5:0]  set;
        logic [19:0] tag;
        logic        chk_tag;
        logic        valid;
        logic        hit;
        logic [1:0]  way;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snoop_en, lru_fill_en;
    logic [5:0]  snoop_set, lru_fill_set;
    logic [3:0]  snoop_valid = '0;
    logic [79:0] snoop_tag = '0;
    logic [1:0]  fill_lru = '0;
    logic [3:0]  dtag_update_en_oh;
    logic [5:0]  dtag_update_set;
    logic [19:0] dtag_update_tag;
    logic        dtag_update_valid;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_e;

    l1d_tag_update_sequencer_if #(.NUM_WAYS(4)) req_if ();

    l1d_tag_update_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .req_if            (req_if),
        .snoop_en          (snoop_en),
        .snoop_set         (snoop_set),
        .lru_fill_en       (lru_fill_en),
        .lru_fill_set      (lru_fill_set),
        .snoop_valid       (snoop_valid),
        .snoop_tag         (snoop_tag),
        .fill_lru          (fill_lru),
        .dtag_update_en_oh (dtag_update_en_oh),
        .dtag_update_set   (dtag_update_set),
        .dtag_update_tag   (dtag_update_tag),
        .dtag_update_valid (dtag_update_valid)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if (!req_if.done_valid && dtag_update_en_oh !== 4'b0) begin
                miscompares++;
                $display("FAIL en_oh_outside_update got=%b want=0000", dtag_update_en_oh);
            end
            if (req_if.done_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done got=1 want=0");
                end else begin
                    mon_e = sb.pop_front();
                    if (dtag_update_en_oh !== mon_e.en) begin
                        miscompares++;
                        $display("FAIL sb_en_oh got=%b want=%b", dtag_update_en_oh, mon_e.en);
                    end
                    if (dtag_update_set !== mon_e.set) begin
                        miscompares++;
                        $display("FAIL sb_set got=%h want=%h", dtag_update_set, mon_e.set);
                    end
                    if (mon_e.chk_tag && dtag_update_tag !== mon_e.tag) begin
                        miscompares++;
                        $display("FAIL sb_tag got=%h want=%h", dtag_update_tag, mon_e.tag);
                    end
                    if (mon_e.en != 4'b0 && dtag_update_valid !== mon_e.valid) begin
                        miscompares++;
                        $display("FAIL sb_valid got=%b want=%b", dtag_update_valid, mon_e.valid);
                    end
                    if (req_if.done_hit !== mon_e.hit) begin
                        miscompares++;
                        $display("FAIL sb_done_hit got=%b want=%b", req_if.done_hit, mon_e.hit);
                    end
                    if (req_if.done_way !== mon_e.way) begin
                        miscompares++;
                        $display("FAIL sb_done_way got=%0d want=%0d", req_if.done_way, mon_e.way);
                    end
                end
            end
        end
    end

    // Present a request and return just after the accepting edge.
    task automatic send(input l1d_tag_op_e op, input logic [31:0] paddr);
        bit ok = 0;
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_op    = op;
        req_if.req_paddr = paddr;
        for (int i = 0; i < 10; i++) begin
            if (req_if.req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL accept_timeout got=ready0 want=ready1");
        end
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        req_if.req_valid = 1'b0;
        req_if.req_op    = TagOpFill;
        req_if.req_paddr = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got=%b want=1", req_if.req_ready);
        end
        vectors++;
        if ({snoop_en, lru_fill_en, req_if.done_valid, req_if.done_hit, dtag_update_valid} !== 5'b0)
        begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {snoop_en, lru_fill_en, req_if.done_valid, req_if.done_hit,
                      dtag_update_valid});
        end
        vectors++;
        if ({snoop_set, lru_fill_set, dtag_update_set, dtag_update_tag, req_if.done_way} !== '0)
        begin
            miscompares++;
            $display("FAIL reset_data got=nonzero want=0");
        end
    endtask

    task automatic test_fill_miss();
        snoop_valid = 4'b0000;
        snoop_tag   = {20'h12345, 20'h12345, 20'h12345, 20'h12345};
        fill_lru    = 2'd2;
        sb.push_back('{en: 4'b0100, set: 6'h19, tag: 20'h12345, chk_tag: 1, valid: 1, hit: 0,
                       way: 2'd2});
        send(TagOpFill, 32'h1234_5640);
        @(negedge clk);
        vectors++;
        if (snoop_en !== 1'b1 || snoop_set !== 6'h19) begin
            miscompares++;
            $display("FAIL fill_snoop got=%b/%h want=1/19", snoop_en, snoop_set);
        end
        vectors++;
        if (lru_fill_en !== 1'b1 || lru_fill_set !== 6'h19 || req_if.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_lru_query got=%b/%h/rdy%b want=1/19/rdy0",
                     lru_fill_en, lru_fill_set, req_if.req_ready);
        end
        @(negedge clk);
        vectors++;
        if (snoop_en !== 1'b0 || req_if.done_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_check got=%b/%b want=0/0", snoop_en, req_if.done_valid);
        end
        @(negedge clk);
        vectors++;
        if (req_if.done_valid !== 1'b1 || dtag_update_en_oh !== 4'b0100) begin
            miscompares++;
            $display("FAIL fill_latency got=%b/%b want=1/0100",
                     req_if.done_valid, dtag_update_en_oh);
        end
        drain();
    endtask

    task automatic test_inval_hit();
        snoop_valid = 4'b0100;
        snoop_tag   = {20'h00001, 20'h12345, 20'h00003, 20'h00004};
        fill_lru    = 2'd1;
        sb.push_back('{en: 4'b0100, set: 6'h19, tag: 20'h0, chk_tag: 0, valid: 0, hit: 1,
                       way: 2'd2});
        send(TagOpInval, 32'h1234_5640);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (lru_fill_en !== 1'b0) begin
                miscompares++;
                $display("FAIL inval_lru_en cyc%0d got=%b want=0", c, lru_fill_en);
            end
        end
        drain();
    endtask

    task automatic test_inval_miss();
        snoop_valid = 4'b1111;
        snoop_tag   = {20'h12344, 20'h12346, 20'h02345, 20'h92345};
        sb.push_back('{en: 4'b0000, set: 6'h19, tag: 20'h0, chk_tag: 0, valid: 0, hit: 0,
                       way: 2'd0});
        send(TagOpInval, 32'h1234_5640);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (dtag_update_en_oh !== 4'b0000) begin
                miscompares++;
                $display("FAIL inval_miss_en cyc%0d got=%b want=0000", c, dtag_update_en_oh);
            end
        end
        drain();
    endtask

    task automatic test_fill_hit();
        snoop_valid = 4'b1111;
        snoop_tag   = {20'h11111, 20'h22222, 20'hABCDE, 20'h33333};
        fill_lru    = 2'd3;
        sb.push_back('{en: 4'b0010, set: 6'h03, tag: 20'hABCDE, chk_tag: 1, valid: 1, hit: 1,
                       way: 2'd1});
        send(TagOpFill, 32'hABCD_E0C0);
        drain();
    endtask

    task automatic test_back_to_back();
        snoop_valid = 4'b0000;
        fill_lru    = 2'd0;
        for (int n = 0; n < 2; n++) begin
            sb.push_back('{en: 4'b0001, set: 6'h2A, tag: 20'h0BEEF, chk_tag: 1, valid: 1,
                           hit: 0, way: 2'd0});
        end
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_op    = TagOpFill;
        req_if.req_paddr = {20'h0BEEF, 6'h2A, 6'h15};
        vectors++;
        if (req_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_ready got=%b want=1", req_if.req_ready);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            vectors++;
            if (req_if.req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_busy cyc%0d got=%b want=0", c, req_if.req_ready);
            end
        end
        @(negedge clk);
        vectors++;
        if (req_if.req_ready !== 1'b1 || snoop_en !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_ready got=%b/%b want=1/0", req_if.req_ready, snoop_en);
        end
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (snoop_en !== 1'b1 || snoop_set !== 6'h2A) begin
            miscompares++;
            $display("FAIL b2b_second_snoop got=%b/%h want=1/2a", snoop_en, snoop_set);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        snoop_valid = 4'b0000;
        fill_lru    = 2'd3;
        send(TagOpFill, 32'h1234_5640);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (dtag_update_en_oh !== 4'b0 || req_if.done_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs got=%b/%b want=0000/0",
                     dtag_update_en_oh, req_if.done_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (req_if.done_valid !== 1'b0 || dtag_update_en_oh !== 4'b0) begin
                miscompares++;
                $display("FAIL rst_mid_dropped cyc%0d got=%b/%b want=0/0000",
                         c, req_if.done_valid, dtag_update_en_oh);
            end
        end
        vectors++;
        if (req_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_ready got=%b want=1", req_if.req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fill_miss();
        test_inval_hit();
        test_inval_miss();
        test_fill_hit();
        test_back_to_back();
        test_reset_mid();
        test_fill_miss();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
